// File: rtl/hsv_core_issue_stage.sv
// Issue stage of the HSV RV32 core: integer register file, RAW pending-write scoreboard
// and a one-entry dispatch register feeding the ALU, branch, ctrl/status and memory units.
package hsv_core_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  typedef struct packed {
    word_t     pc;
    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    reg_addr_t rd_addr;
    word_t     immediate;
  } common_t;

  typedef struct packed {
    logic alu;
    logic branch;
    logic ctrl_status;
    logic mem;
  } exec_select_t;

  typedef struct packed { logic [3:0] op; } alu_payload_t;
  typedef struct packed { logic [3:0] op; } branch_payload_t;
  typedef struct packed { logic [3:0] op; logic [11:0] csr_addr; } ctrl_status_payload_t;
  typedef struct packed { logic [3:0] op; } mem_payload_t;

  typedef struct packed {
    common_t              common;
    exec_select_t         exec_select;
    alu_payload_t         alu;
    branch_payload_t      branch;
    ctrl_status_payload_t ctrl_status;
    mem_payload_t         mem;
  } issue_data_t;

  typedef struct packed {
    common_t      common;
    word_t        rs1_value;
    word_t        rs2_value;
    alu_payload_t payload;
  } alu_data_t;

  typedef struct packed {
    common_t         common;
    word_t           rs1_value;
    word_t           rs2_value;
    branch_payload_t payload;
  } branch_data_t;

  typedef struct packed {
    common_t              common;
    word_t                rs1_value;
    word_t                rs2_value;
    ctrl_status_payload_t payload;
  } ctrl_status_data_t;

  typedef struct packed {
    common_t      common;
    word_t        rs1_value;
    word_t        rs2_value;
    mem_payload_t payload;
  } mem_data_t;
endpackage

module hsv_core_issue_stage
  import hsv_core_pkg::*;
(
  input  logic              clk_core,
  input  logic              rst_core_n,
  input  logic              flush_req,
  output logic              flush_ack,
  input  issue_data_t       issue_data,
  input  logic              valid_i,
  output logic              ready_o,
  output alu_data_t         alu_data,
  output branch_data_t      branch_data,
  output ctrl_status_data_t ctrl_status_data,
  output mem_data_t         mem_data,
  input  logic              alu_ready_i,
  input  logic              branch_ready_i,
  input  logic              ctrl_status_ready_i,
  input  logic              mem_ready_i,
  output logic              alu_valid_o,
  output logic              branch_valid_o,
  output logic              ctrl_status_valid_o,
  output logic              mem_valid_o,
  input  logic [4:0]        wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              wr_en,
  input  logic [31:0]       commit_mask
);
  logic [31:0]       regs [32];
  word_t             rs1_value;
  word_t             rs2_value;
  reg_addr_t         rs1_addr;
  reg_addr_t         rs2_addr;
  reg_addr_t         rd_addr;
  logic [31:0]       pending;
  logic [31:0]       pending_live;
  logic [31:0]       pending_set;
  logic              hazard;
  logic              out_free;
  logic              held_ready;
  logic              accept;
  logic              flush_ack_q;
  logic [3:0]        valid_q;
  logic [3:0]        unit_ready;
  logic [3:0]        sel;
  alu_data_t         alu_q;
  branch_data_t      branch_q;
  ctrl_status_data_t ctrl_status_q;
  mem_data_t         mem_q;

  assign rs1_addr = issue_data.common.rs1_addr;
  assign rs2_addr = issue_data.common.rs2_addr;
  assign rd_addr  = issue_data.common.rd_addr;

  // Operand read with write-first bypass from the writeback port; x0 is hardwired to zero.
  always_comb begin
    rs1_value = '0;
    rs2_value = '0;
    if (rs1_addr != '0) rs1_value = (wr_en && wr_addr == rs1_addr) ? wr_data : regs[rs1_addr];
    if (rs2_addr != '0) rs2_value = (wr_en && wr_addr == rs2_addr) ? wr_data : regs[rs2_addr];
  end

  // A register committed this very cycle no longer counts as a hazard.
  assign pending_live = pending & ~commit_mask;
  assign hazard = (rs1_addr != '0 && pending_live[rs1_addr]) ||
                  (rs2_addr != '0 && pending_live[rs2_addr]);

  // Handshake: a transfer happens on any edge where valid and ready are both 1; a raised
  // valid and its data stay unchanged until that edge, and ready never depends on valid.
  assign unit_ready = {alu_ready_i, branch_ready_i, ctrl_status_ready_i, mem_ready_i};
  assign held_ready = |(valid_q & unit_ready);
  assign out_free   = (valid_q == '0) || held_ready;
  assign ready_o    = out_free && !hazard && !flush_req && !rst_core_n;
  assign accept     = valid_i && ready_o;

  always_comb begin
    sel = '0;
    if (issue_data.exec_select.alu)              sel = 4'b1000;
    else if (issue_data.exec_select.branch)      sel = 4'b0100;
    else if (issue_data.exec_select.ctrl_status) sel = 4'b0010;
    else if (issue_data.exec_select.mem)         sel = 4'b0001;
  end

  always_comb begin
    pending_set = '0;
    if (accept && rd_addr != '0) pending_set[rd_addr] = 1'b1;
  end

  always_ff @(posedge clk_core) begin
    if (rst_core_n) begin
      valid_q     <= '0;
      pending     <= '0;
      flush_ack_q <= 1'b0;
    end else begin
      flush_ack_q <= flush_req;
      if (flush_req) begin
        valid_q <= '0;
        pending <= '0;
      end else begin
        pending <= pending_live | pending_set;
        if (accept)          valid_q <= sel;
        else if (held_ready) valid_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst_core_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Only the selected unit's register is loaded; the others keep their last contents.
  always_ff @(posedge clk_core) begin
    if (accept) begin
      if (sel[3]) begin
        alu_q.common    <= issue_data.common;
        alu_q.rs1_value <= rs1_value;
        alu_q.rs2_value <= rs2_value;
        alu_q.payload   <= issue_data.alu;
      end
      if (sel[2]) begin
        branch_q.common    <= issue_data.common;
        branch_q.rs1_value <= rs1_value;
        branch_q.rs2_value <= rs2_value;
        branch_q.payload   <= issue_data.branch;
      end
      if (sel[1]) begin
        ctrl_status_q.common    <= issue_data.common;
        ctrl_status_q.rs1_value <= rs1_value;
        ctrl_status_q.rs2_value <= rs2_value;
        ctrl_status_q.payload   <= issue_data.ctrl_status;
      end
      if (sel[0]) begin
        mem_q.common    <= issue_data.common;
        mem_q.rs1_value <= rs1_value;
        mem_q.rs2_value <= rs2_value;
        mem_q.payload   <= issue_data.mem;
      end
    end
  end

  assign alu_data            = alu_q;
  assign branch_data         = branch_q;
  assign ctrl_status_data    = ctrl_status_q;
  assign mem_data            = mem_q;
  assign alu_valid_o         = valid_q[3];
  assign branch_valid_o      = valid_q[2];
  assign ctrl_status_valid_o = valid_q[1];
  assign mem_valid_o         = valid_q[0];
  assign flush_ack           = flush_ack_q;
endmodule

// File: tb/tb_hsv_core_issue_stage.sv
// Bench for hsv_core_issue_stage: hand sequences for reset/flush/hazard/bypass corners and a
// table of dispatch vectors, with every unit transfer checked against an expected queue.
module tb_hsv_core_issue_stage;
  import hsv_core_pkg::*;

  localparam int W = 139;

  logic              clk_core = 1'b0;
  logic              rst_core_n;
  logic              flush_req;
  logic              flush_ack;
  issue_data_t       issue_data;
  logic              valid_i;
  logic              ready_o;
  alu_data_t         alu_data;
  branch_data_t      branch_data;
  ctrl_status_data_t ctrl_status_data;
  mem_data_t         mem_data;
  logic              alu_ready_i;
  logic              branch_ready_i;
  logic              ctrl_status_ready_i;
  logic              mem_ready_i;
  logic              alu_valid_o;
  logic              branch_valid_o;
  logic              ctrl_status_valid_o;
  logic              mem_valid_o;
  logic [4:0]        wr_addr;
  logic [31:0]       wr_data;
  logic              wr_en;
  logic [31:0]       commit_mask;

  logic [W-1:0] exp_q[$];
  logic [31:0]  model [32];
  int           n_checks = 0;
  int           n_fail = 0;
  bit           rand_ready = 1'b0;

  typedef struct {
    logic [3:0]  sel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  op;
    int          exp_unit;
  } vec_t;
  vec_t vecs[12];

  hsv_core_issue_stage dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n), .flush_req(flush_req), .flush_ack(flush_ack),
    .issue_data(issue_data), .valid_i(valid_i), .ready_o(ready_o),
    .alu_data(alu_data), .branch_data(branch_data), .ctrl_status_data(ctrl_status_data),
    .mem_data(mem_data), .alu_ready_i(alu_ready_i), .branch_ready_i(branch_ready_i),
    .ctrl_status_ready_i(ctrl_status_ready_i), .mem_ready_i(mem_ready_i),
    .alu_valid_o(alu_valid_o), .branch_valid_o(branch_valid_o),
    .ctrl_status_valid_o(ctrl_status_valid_o), .mem_valid_o(mem_valid_o),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .commit_mask(commit_mask)
  );

  // Clock and register-file model.
  always #5 clk_core = ~clk_core;

  always @(posedge clk_core) begin
    if (rst_core_n) begin
      for (int i = 0; i < 32; i++) model[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      model[wr_addr] <= wr_data;
    end
  end

  always @(posedge clk_core) begin
    if (rand_ready) begin
      #1;
      alu_ready_i         = ($urandom_range(0, 3) != 0);
      branch_ready_i      = ($urandom_range(0, 3) != 0);
      ctrl_status_ready_i = ($urandom_range(0, 3) != 0);
      mem_ready_i         = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] expect_of(input int unit, input logic [31:0] pc,
      input logic [31:0] v1, input logic [31:0] v2, input logic [4:0] rd,
      input logic [31:0] imm, input logic [3:0] op);
    return {2'(unit), pc, v1, v2, rd, imm, op ^ 4'(unit)};
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == '0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return model[a];
  endfunction

  // Scoreboard: each completed unit transfer pops and compares the oldest expectation.
  task automatic pop_cmp(input string name, input logic [W-1:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected transfer %0h, expected none", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  always @(negedge clk_core) begin
    if (!rst_core_n) begin
      check("valid_onehot", W'($onehot0({alu_valid_o, branch_valid_o, ctrl_status_valid_o,
                                          mem_valid_o})), W'(1));
      if (alu_valid_o && alu_ready_i)
        pop_cmp("alu_xfer", {2'd0, alu_data.common.pc, alu_data.rs1_value, alu_data.rs2_value,
                             alu_data.common.rd_addr, alu_data.common.immediate, alu_data.payload.op});
      if (branch_valid_o && branch_ready_i)
        pop_cmp("branch_xfer", {2'd1, branch_data.common.pc, branch_data.rs1_value,
                                branch_data.rs2_value, branch_data.common.rd_addr,
                                branch_data.common.immediate, branch_data.payload.op});
      if (ctrl_status_valid_o && ctrl_status_ready_i)
        pop_cmp("ctrl_status_xfer", {2'd2, ctrl_status_data.common.pc, ctrl_status_data.rs1_value,
                                     ctrl_status_data.rs2_value, ctrl_status_data.common.rd_addr,
                                     ctrl_status_data.common.immediate,
                                     ctrl_status_data.payload.op});
      if (mem_valid_o && mem_ready_i)
        pop_cmp("mem_xfer", {2'd3, mem_data.common.pc, mem_data.rs1_value, mem_data.rs2_value,
                             mem_data.common.rd_addr, mem_data.common.immediate, mem_data.payload.op});
    end
  end

  // Driver tasks; all are entered and left just after a rising edge.
  task automatic set_fields(input logic [3:0] sel, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] op);
    issue_data.common.pc           = pc;
    issue_data.common.rs1_addr     = rs1;
    issue_data.common.rs2_addr     = rs2;
    issue_data.common.rd_addr      = rd;
    issue_data.common.immediate    = imm;
    issue_data.exec_select         = exec_select_t'(sel);
    issue_data.alu.op              = op;
    issue_data.branch.op           = op ^ 4'h1;
    issue_data.ctrl_status.op      = op ^ 4'h2;
    issue_data.ctrl_status.csr_addr = 12'h300;
    issue_data.mem.op              = op ^ 4'h3;
  endtask

  task automatic issue(input logic [3:0] sel, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] op,
      input int exp_unit, input bit last);
    int waited = 0;
    set_fields(sel, rs1, rs2, rd, pc, imm, op);
    valid_i = 1'b1;
    @(negedge clk_core);
    while (!ready_o && waited < 40) begin
      waited++;
      @(negedge clk_core);
    end
    if (!ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: ready_o stayed 0 for pc %0h", pc);
    end else if (exp_unit < 4) begin
      exp_q.push_back(expect_of(exp_unit, pc, ref_read(rs1), ref_read(rs2), rd, imm, op));
    end
    @(posedge clk_core);
    #1;
    if (last) valid_i = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk_core);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_core);
    #1;
  endtask

  initial begin
    rst_core_n = 1'b1; flush_req = 1'b0; valid_i = 1'b0; issue_data = '0;
    alu_ready_i = 1'b1; branch_ready_i = 1'b1; ctrl_status_ready_i = 1'b1; mem_ready_i = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit_mask = '1;

    // Reset state, then a one-cycle flush pulse.
    repeat (3) @(posedge clk_core);
    @(negedge clk_core);
    check("reset_ready", W'(ready_o), W'(0));
    check("reset_valids", W'({alu_valid_o, branch_valid_o, ctrl_status_valid_o, mem_valid_o}), W'(0));
    check("reset_flush_ack", W'(flush_ack), W'(0));
    @(posedge clk_core); #1;
    rst_core_n = 1'b0;
    @(negedge clk_core);
    check("post_reset_ready", W'(ready_o), W'(1));
    @(posedge clk_core); #1;
    flush_req = 1'b1;
    @(negedge clk_core);
    check("ready_during_flush", W'(ready_o), W'(0));
    @(posedge clk_core); #1;
    flush_req = 1'b0;
    @(negedge clk_core);
    check("flush_ack_high", W'(flush_ack), W'(1));
    check("flush_valids", W'({alu_valid_o, branch_valid_o, ctrl_status_valid_o, mem_valid_o}), W'(0));
    @(posedge clk_core); #1;
    @(negedge clk_core);
    check("flush_ack_low", W'(flush_ack), W'(0));
    check("ready_after_flush", W'(ready_o), W'(1));
    @(posedge clk_core); #1;

    // x0 ignores writes; x1 written then read.
    write_reg(5'd0, 32'hDEADBEEF);
    write_reg(5'd1, 32'h12345678);
    issue(4'b1000, 5'd0, 5'd1, 5'd0, 32'h40, 32'h0, 4'h2, 0, 1'b1);
    idle(2);

    // ALU op held while the ALU is not ready.
    alu_ready_i = 1'b0;
    issue(4'b1000, 5'd1, 5'd0, 5'd5, 32'h0, 32'h4, 4'h3, 0, 1'b1);
    repeat (3) begin
      @(negedge clk_core);
      check("hold_alu_valid", W'(alu_valid_o), W'(1));
      check("hold_other_valids", W'({branch_valid_o, ctrl_status_valid_o, mem_valid_o}), W'(0));
      check("hold_alu_data", {2'd0, alu_data.common.pc, alu_data.rs1_value, alu_data.rs2_value,
                              alu_data.common.rd_addr, alu_data.common.immediate,
                              alu_data.payload.op},
            expect_of(0, 32'h0, 32'h12345678, 32'h0, 5'd5, 32'h4, 4'h3));
    end
    @(posedge clk_core); #1;
    alu_ready_i = 1'b1;
    @(posedge clk_core); #1;
    @(negedge clk_core);
    check("alu_valid_dropped", W'(alu_valid_o), W'(0));
    @(posedge clk_core); #1;

    // Same-cycle write bypass onto rs2.
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h87654321;
    issue(4'b1000, 5'd1, 5'd2, 5'd0, 32'h80, 32'h8, 4'h5, 0, 1'b1);
    wr_en = 1'b0;
    idle(2);

    // RAW hazard on x5 until it is committed.
    commit_mask = '0;
    issue(4'b1000, 5'd0, 5'd0, 5'd5, 32'hC0, 32'h1, 4'h1, 0, 1'b1);
    set_fields(4'b1000, 5'd5, 5'd0, 5'd6, 32'hC4, 32'h2, 4'h4);
    valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk_core);
      check("hazard_stall", W'(ready_o), W'(0));
    end
    @(posedge clk_core); #1;
    commit_mask = 32'h20;
    @(negedge clk_core);
    check("hazard_release", W'(ready_o), W'(1));
    if (ready_o) exp_q.push_back(expect_of(0, 32'hC4, model[5], 32'h0, 5'd6, 32'h2, 4'h4));
    @(posedge clk_core); #1;
    valid_i = 1'b0;
    commit_mask = '0;
    idle(2);

    // Flush while the ALU holds an instruction and x5 is pending.
    alu_ready_i = 1'b0;
    issue(4'b1000, 5'd1, 5'd0, 5'd5, 32'h100, 32'h3, 4'h6, 0, 1'b1);
    @(negedge clk_core);
    check("valid_before_flush", W'(alu_valid_o), W'(1));
    @(posedge clk_core); #1;
    flush_req = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(posedge clk_core); #1;
    flush_req = 1'b0;
    @(negedge clk_core);
    check("flush_clears_valid", W'(alu_valid_o), W'(0));
    check("flush_ack_set", W'(flush_ack), W'(1));
    set_fields(4'b1000, 5'd5, 5'd1, 5'd0, 32'h104, 32'h0, 4'h7);
    @(negedge clk_core);
    check("no_hazard_after_flush", W'(ready_o), W'(1));
    @(posedge clk_core); #1;
    alu_ready_i = 1'b1;
    issue(4'b1000, 5'd5, 5'd1, 5'd0, 32'h104, 32'h0, 4'h7, 0, 1'b1);
    idle(2);

    // Table of dispatch vectors, back-to-back, with random unit readiness.
    commit_mask = '1;
    for (int r = 3; r < 9; r++) write_reg(5'(r), $urandom());
    vecs[0]  = '{4'b1000, 5'd3, 5'd4, 5'd9,  32'h200, 32'h11, 4'h1, 0};
    vecs[1]  = '{4'b0100, 5'd5, 5'd6, 5'd10, 32'h204, 32'h22, 4'h2, 1};
    vecs[2]  = '{4'b0010, 5'd7, 5'd8, 5'd11, 32'h208, 32'h33, 4'h3, 2};
    vecs[3]  = '{4'b0001, 5'd1, 5'd2, 5'd12, 32'h20C, 32'h44, 4'h4, 3};
    vecs[4]  = '{4'b0000, 5'd3, 5'd3, 5'd13, 32'h210, 32'h55, 4'h5, 4};
    vecs[5]  = '{4'b1100, 5'd4, 5'd5, 5'd14, 32'h214, 32'h66, 4'h6, 0};
    vecs[6]  = '{4'b0110, 5'd6, 5'd7, 5'd15, 32'h218, 32'h77, 4'h7, 1};
    vecs[7]  = '{4'b0011, 5'd8, 5'd0, 5'd16, 32'h21C, 32'h88, 4'h8, 2};
    vecs[8]  = '{4'b1111, 5'd2, 5'd1, 5'd17, 32'h220, 32'h99, 4'h9, 0};
    vecs[9]  = '{4'b0001, 5'd0, 5'd9, 5'd0,  32'h224, 32'hAA, 4'hA, 3};
    vecs[10] = '{4'b0100, 5'd2, 5'd2, 5'd31, 32'h228, 32'hBB, 4'hB, 1};
    vecs[11] = '{4'b0010, 5'd31, 5'd3, 5'd1, 32'h22C, 32'hCC, 4'hC, 2};
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++)
      issue(vecs[i].sel, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].pc, vecs[i].imm,
            vecs[i].op, vecs[i].exp_unit, i == 11);
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk_core);
    check("queue_drained", W'(exp_q.size()), W'(0));
    rand_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
